if_fetch_unit: RTL and testbench

Instruction fetch unit. Consumes the `pc`/`ce` fetch request from the PC register and reads the 32-bit instruction from the byte-wide unified memory port, one byte at a time, little-endian. It holds the pipeline stalled through `stallreq_o` (feeds `stall[0]`) until the word is assembled. It then presents the instruction with its address to the IF/ID register, and aborts cleanly on a branch flush.

---
 rtl/if_fetch_unit.sv | 138 +++++++++++++
 tb/tb_if_fetch_unit.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: assembles a 32-bit little-endian instruction from four
// byte reads on the unified memory port, stalling the front end until it is done.
module if_fetch_unit #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] pc_i,
  input  logic                  ce_i,
  input  logic                  flush_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_rd_o,
  input  logic                  mem_busy_i,
  input  logic [7:0]            mem_data_i,
  input  logic                  mem_valid_i,
  output logic                  stallreq_o,
  output logic [31:0]           inst_o,
  output logic [ADDR_WIDTH-1:0] inst_pc_o,
  output logic                  inst_valid_o
);

  // Memory handshake: a request is offered while mem_rd_o=1 and transfers on a
  // cycle with mem_busy_i=0; address and strobe hold while busy. Exactly one
  // mem_valid_i pulse returns per accepted request, at least one cycle later.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t                state_q;
  logic [1:0]            k_q;
  logic [ADDR_WIDTH-1:0] fetch_pc_q;
  logic [23:0]           buf_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic                  mem_rd_q;
  logic [31:0]           inst_q;
  logic [ADDR_WIDTH-1:0] inst_pc_q;

  logic [1:0]            k_inc;
  logic [ADDR_WIDTH-1:0] next_addr;

  always_comb begin
    k_inc     = k_q + 2'd1;
    next_addr = fetch_pc_q + ADDR_WIDTH'(k_inc);
  end

  // Only bytes 0..2 are buffered; byte 3 goes straight into inst_q on DONE entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      k_q        <= 2'd0;
      fetch_pc_q <= '0;
      buf_q      <= '0;
      mem_addr_q <= '0;
      mem_rd_q   <= 1'b0;
      inst_q     <= '0;
      inst_pc_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ce_i && !flush_i) begin
            fetch_pc_q <= pc_i;
            k_q        <= 2'd0;
            mem_addr_q <= pc_i;
            mem_rd_q   <= 1'b1;
            state_q    <= REQ;
          end
        end
        REQ: begin
          if (flush_i) begin
            mem_rd_q <= 1'b0;
            state_q  <= mem_busy_i ? IDLE : DRAIN;
          end else if (!mem_busy_i) begin
            mem_rd_q <= 1'b0;
            state_q  <= WAIT;
          end
        end
        WAIT: begin
          if (mem_valid_i) begin
            if (flush_i) begin
              state_q <= IDLE;
            end else if (k_q == 2'd3) begin
              inst_q    <= {mem_data_i, buf_q};
              inst_pc_q <= fetch_pc_q;
              state_q   <= DONE;
            end else begin
              case (k_q)
                2'd0:    buf_q[7:0]   <= mem_data_i;
                2'd1:    buf_q[15:8]  <= mem_data_i;
                default: buf_q[23:16] <= mem_data_i;
              endcase
              k_q        <= k_inc;
              mem_addr_q <= next_addr;
              mem_rd_q   <= 1'b1;
              state_q    <= REQ;
            end
          end else if (flush_i) begin
            state_q <= DRAIN;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        DRAIN: begin
          if (mem_valid_i) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // A flush always releases the stall so the PC can load the branch target.
  always_comb begin
    stallreq_o = 1'b0;
    case (state_q)
      IDLE:              stallreq_o = ce_i;
      REQ, WAIT, DRAIN:  stallreq_o = 1'b1;
      default:           stallreq_o = 1'b0;
    endcase
    if (flush_i || rst) begin
      stallreq_o = 1'b0;
    end
  end

  assign inst_valid_o = (state_q == DONE) && !flush_i && !rst;
  assign mem_addr_o   = mem_addr_q;
  assign mem_rd_o     = mem_rd_q;
  assign inst_o       = inst_q;
  assign inst_pc_o    = inst_pc_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: behavioural byte memory with planned busy/latency,
// an expected-instruction queue checked by a monitor, and cycle-count checks.
module tb_if_fetch_unit;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] pc_i = '0;
  logic          ce_i = 1'b0;
  logic          flush_i = 1'b0;
  logic [AW-1:0] mem_addr_o;
  logic          mem_rd_o;
  logic          mem_busy_i = 1'b0;
  logic [7:0]    mem_data_i = '0;
  logic          mem_valid_i = 1'b0;
  logic          stallreq_o;
  logic [31:0]   inst_o;
  logic [AW-1:0] inst_pc_o;
  logic          inst_valid_o;

  if_fetch_unit #(.ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_i         (pc_i),
    .ce_i         (ce_i),
    .flush_i      (flush_i),
    .mem_addr_o   (mem_addr_o),
    .mem_rd_o     (mem_rd_o),
    .mem_busy_i   (mem_busy_i),
    .mem_data_i   (mem_data_i),
    .mem_valid_i  (mem_valid_i),
    .stallreq_o   (stallreq_o),
    .inst_o       (inst_o),
    .inst_pc_o    (inst_pc_o),
    .inst_valid_o (inst_valid_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [63:0] exp_q[$];       // {pc, instruction}
  logic [31:0] addr_exp_q[$];
  logic [7:0]  mem_init [logic [31:0]];
  int busy_plan[4];
  int lat_plan[4];
  int rd_cycles[4];
  int req_idx = 0;
  bit spurious_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: event occurred that must not occur", name);
  endtask

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    if (mem_init.exists(a)) return mem_init[a];
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'hA5;
  endfunction

  task automatic set_plan(input int b0, input int b1, input int b2, input int b3,
                          input int l0, input int l1, input int l2, input int l3);
    busy_plan[0] = b0; busy_plan[1] = b1; busy_plan[2] = b2; busy_plan[3] = b3;
    lat_plan[0]  = l0; lat_plan[1]  = l1; lat_plan[2]  = l2; lat_plan[3]  = l3;
  endtask

  // Cycle index (IDLE latch cycle = 1) of the REQ cycle in which byte b is accepted.
  function automatic int req_cycle(input int b);
    int s = 2;
    for (int j = 0; j < b; j++) s += 1 + busy_plan[j] + lat_plan[j];
    return s + busy_plan[b];
  endfunction

  function automatic int done_cycle();
    int s = 2;
    for (int j = 0; j < 4; j++) s += 1 + busy_plan[j] + lat_plan[j];
    return s;
  endfunction

  // Memory model: busy for the planned cycles, answer lat_plan cycles after acceptance.
  initial begin : responder
    bit          pend;
    int          cnt;
    logic [7:0]  data;
    bit          hold;
    logic [31:0] hold_addr;
    logic [31:0] ea;
    int          busy_left;
    pend = 0; cnt = 0; data = '0; hold = 0; hold_addr = '0; busy_left = 0;
    forever begin
      @(negedge clk);
      mem_valid_i = 1'b0;
      mem_data_i  = 8'($urandom);
      if (rst) begin
        pend = 0;
        hold = 0;
        mem_busy_i = 1'b0;
      end else begin
        if (pend) begin
          if (cnt <= 1) begin
            mem_valid_i = 1'b1;
            mem_data_i  = data;
            pend = 0;
          end else begin
            cnt--;
          end
        end else if (spurious_en && $urandom_range(0, 3) == 0) begin
          mem_valid_i = 1'b1;
        end
        if (hold) begin
          chk("busy_hold_rd", mem_rd_o, 1);
          chk("busy_hold_addr", mem_addr_o, hold_addr);
        end
        if (mem_rd_o) begin
          if (!hold) begin
            busy_left = (req_idx < 4) ? busy_plan[req_idx] : 0;
            hold_addr = mem_addr_o;
          end
          if (req_idx < 4) rd_cycles[req_idx]++;
          if (busy_left > 0) begin
            mem_busy_i = 1'b1;
            busy_left--;
            hold = 1;
          end else begin
            mem_busy_i = 1'b0;
            hold = 0;
            if (pend) fail("one_outstanding");
            if (addr_exp_q.size() == 0) begin
              fail("unexpected_mem_req");
            end else begin
              ea = addr_exp_q.pop_front();
              chk("mem_addr", mem_addr_o, ea);
            end
            data = mem_byte(mem_addr_o);
            cnt  = (req_idx < 4) ? lat_plan[req_idx] : 1;
            pend = 1;
            req_idx++;
          end
        end else begin
          mem_busy_i = 1'b0;
          hold = 0;
        end
      end
    end
  end

  initial begin : monitor
    logic [63:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (inst_valid_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          fail("unexpected_inst_valid");
        end else begin
          e = exp_q.pop_front();
          chk("inst", inst_o, e[31:0]);
          chk("inst_pc", inst_pc_o, e[63:32]);
        end
      end
    end
  end

  // One fetch as the PC register would issue it; optionally aborted by flush or rst
  // at cycle abort_cyc. after_stall is the stall expected the cycle after a flush.
  task automatic fetch(input logic [31:0] pc, input bit chk_time, input int abort_cyc,
                       input bit abort_rst, input int after_stall);
    logic [31:0] w;
    int exp_done;
    int cyc;
    int stall_n;
    bit seen;
    w = {mem_byte(pc + 32'd3), mem_byte(pc + 32'd2), mem_byte(pc + 32'd1), mem_byte(pc)};
    exp_done = done_cycle();
    exp_q.push_back({pc, w});
    for (int b = 0; b < 4; b++) addr_exp_q.push_back(pc + 32'(b));
    @(negedge clk);
    req_idx = 0;
    for (int b = 0; b < 4; b++) rd_cycles[b] = 0;
    pc_i = pc;
    ce_i = 1'b1;
    cyc = 1;
    stall_n = 0;
    seen = 0;
    #1;
    if (stallreq_o) stall_n++;
    while (!seen && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (cyc == abort_cyc) begin
        ce_i = 1'b0;
        if (abort_rst) begin
          rst = 1'b1;
          @(negedge clk);
          #1;
          chk("rst_mem_rd", mem_rd_o, 0);
          chk("rst_mem_addr", mem_addr_o, 0);
          chk("rst_stall", stallreq_o, 0);
          chk("rst_inst", inst_o, 0);
          chk("rst_inst_pc", inst_pc_o, 0);
          chk("rst_inst_valid", inst_valid_o, 0);
          @(negedge clk);
          rst = 1'b0;
        end else begin
          flush_i = 1'b1;
          #1;
          chk("flush_stall", stallreq_o, 0);
          chk("flush_inst_valid", inst_valid_o, 0);
          @(negedge clk);
          flush_i = 1'b0;
          #1;
          if (after_stall >= 0) chk("post_flush_stall", stallreq_o, 64'(after_stall));
        end
        void'(exp_q.pop_back());
        addr_exp_q.delete();
        return;
      end
      #1;
      if (stallreq_o) stall_n++;
      if (inst_valid_o) seen = 1;
    end
    ce_i = 1'b0;
    if (!seen) begin
      fail("fetch_timeout");
      if (exp_q.size() > 0) void'(exp_q.pop_back());
      addr_exp_q.delete();
    end else if (chk_time) begin
      chk("done_cycle", cyc, exp_done);
      chk("stall_cycles", stall_n, exp_done - 1);
      for (int b = 0; b < 4; b++) chk("rd_cycles", rd_cycles[b], 1 + busy_plan[b]);
    end
  endtask

  initial begin : stimulus
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_mem_rd", mem_rd_o, 0);
    chk("reset_mem_addr", mem_addr_o, 0);
    chk("reset_stall", stallreq_o, 0);
    chk("reset_inst", inst_o, 0);
    chk("reset_inst_pc", inst_pc_o, 0);
    chk("reset_inst_valid", inst_valid_o, 0);
    @(negedge clk);
    rst = 1'b0;

    // basic fetch of 0x00100513 from address 0
    mem_init[32'h0] = 8'h13;
    mem_init[32'h1] = 8'h05;
    mem_init[32'h2] = 8'h10;
    mem_init[32'h3] = 8'h00;
    set_plan(0, 0, 0, 0, 1, 1, 1, 1);
    fetch(32'h0, 1, 0, 0, -1);

    // busy held for 3 cycles on byte 1
    set_plan(0, 3, 0, 0, 1, 1, 1, 1);
    fetch(32'h4, 1, 0, 0, -1);

    // flush in the first WAIT cycle of byte 2, late byte must be drained
    set_plan(0, 0, 0, 0, 1, 1, 4, 1);
    fetch(32'h40, 1, req_cycle(2) + 1, 0, 1);
    set_plan(0, 0, 0, 0, 1, 1, 1, 1);
    fetch(32'h100, 0, 0, 0, -1);

    // address wrap
    set_plan(0, 0, 0, 0, 2, 1, 1, 2);
    fetch(32'hFFFF_FFFE, 1, 0, 0, -1);

    // reset during WAIT for byte 1, then a clean fetch
    set_plan(0, 0, 0, 0, 1, 4, 1, 1);
    fetch(32'h200, 1, req_cycle(1) + 1, 1, -1);
    set_plan(0, 0, 0, 0, 1, 1, 1, 1);
    fetch(32'h300, 1, 0, 0, -1);

    // flush in REQ with the request accepted: drain, then refetch
    set_plan(0, 0, 0, 0, 3, 1, 1, 1);
    fetch(32'h400, 1, req_cycle(0), 0, 1);
    set_plan(1, 0, 2, 0, 1, 2, 1, 3);
    fetch(32'h404, 0, 0, 0, -1);

    // flush in DONE suppresses the pulse
    set_plan(0, 1, 0, 0, 1, 1, 2, 1);
    fetch(32'h500, 1, done_cycle(), 0, 0);
    set_plan(0, 0, 0, 0, 1, 1, 1, 1);
    fetch(32'h504, 1, 0, 0, -1);

    // disabled: no activity even with stray mem_valid_i pulses
    spurious_en = 1'b1;
    repeat (20) begin
      @(negedge clk);
      #1;
      chk("disabled_outputs", {mem_rd_o, stallreq_o, inst_valid_o}, 0);
    end
    spurious_en = 1'b0;
    repeat (2) @(negedge clk);

    // randomized fetches
    repeat (40) begin
      set_plan($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
               $urandom_range(1, 3), $urandom_range(1, 3), $urandom_range(1, 3), $urandom_range(1, 3));
      fetch($urandom, 1, 0, 0, -1);
    end

    repeat (5) @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
